adder_tree_pipe: RTL and testbench

- Parametrised, fully pipelined successor to the fixed 8-input / 3-level adder tree.
- Sums NUM_INPUTS lanes of IN_WIDTH bits through a balanced binary tree, with one register stage per level.
- Adds a valid/ready handshake with whole-pipeline backpressure, a signed/unsigned mode, and an optional running accumulation across consecutive input vectors.
- Sits between lane-parallel datapaths (MAC arrays, reduction units) and downstream consumers that may stall.

---
 rtl/adder_tree_pipe.sv | 107 ++++++++++
 tb/tb_adder_tree_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_pipe.sv
// rtl/adder_tree_pipe.sv - pipelined binary adder tree with valid/ready backpressure and optional accumulation
module adder_tree_pipe #(
    parameter int NUM_INPUTS = 8,
    parameter int IN_WIDTH   = 128,
    parameter int SIGNED     = 0,
    parameter int ACC_EN     = 0,
    parameter int ACC_WIDTH  = IN_WIDTH + $clog2(NUM_INPUTS) + 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0] in_data,
    input  logic                           in_first,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [ACC_WIDTH-1:0]           out_sum,
    output logic                           out_valid,
    input  logic                           out_ready
);
    localparam int LEVELS = $clog2(NUM_INPUTS);
    localparam int TW     = IN_WIDTH + LEVELS;

    // Bit offset of level k inside the flattened tree register; level k holds
    // NUM_INPUTS>>k values of IN_WIDTH+k bits each.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int m = 0; m < k; m++) begin
            o += (NUM_INPUTS >> m) * (IN_WIDTH + m);
        end
        return o;
    endfunction

    localparam int TOT = lvl_off(LEVELS + 1);

    generate
        if ((NUM_INPUTS < 2) || (NUM_INPUTS > 64) || ((NUM_INPUTS & (NUM_INPUTS - 1)) != 0)) begin : g_bad_num
            $error("adder_tree_pipe: NUM_INPUTS must be a power of two in 2..64");
        end
        if (ACC_WIDTH < TW) begin : g_bad_acc
            $error("adder_tree_pipe: ACC_WIDTH must be >= IN_WIDTH+LEVELS");
        end
    endgenerate

    logic [TOT-1:0]       r_tree;
    logic [TOT-1:0]       w_tree_d;
    logic [LEVELS:0]      r_vld;
    logic [LEVELS:0]      r_fst;
    logic                 w_adv;
    logic                 w_acc;
    logic [TW-1:0]        w_root;
    logic [ACC_WIDTH-1:0] w_root_ext;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_tree_d[NUM_INPUTS*IN_WIDTH-1:0] = in_data;

    generate
        for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
            for (genvar j = 0; j < (NUM_INPUTS >> k); j++) begin : g_pair
                localparam int OW  = IN_WIDTH + k - 1;
                localparam int SRC = lvl_off(k - 1) + 2 * j * OW;
                localparam int DST = lvl_off(k) + j * (OW + 1);
                logic [OW-1:0] w_a;
                logic [OW-1:0] w_b;
                logic          w_ea;
                logic          w_eb;
                assign w_a  = r_tree[SRC +: OW];
                assign w_b  = r_tree[SRC + OW +: OW];
                assign w_ea = (SIGNED != 0) && w_a[OW-1];
                assign w_eb = (SIGNED != 0) && w_b[OW-1];
                assign w_tree_d[DST +: OW + 1] = {w_ea, w_a} + {w_eb, w_b};
            end
        end
    endgenerate

    assign w_root = r_tree[lvl_off(LEVELS) +: TW];

    generate
        if (SIGNED != 0) begin : g_sext
            assign w_root_ext = ACC_WIDTH'($signed(w_root));
        end else begin : g_zext
            assign w_root_ext = ACC_WIDTH'(w_root);
        end
    endgenerate

    assign w_acc = (ACC_EN != 0) && !r_fst[LEVELS];

    // The whole pipeline, output register included, moves in lockstep on w_adv.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tree    <= '0;
            r_vld     <= '0;
            r_fst     <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (w_adv) begin
            r_tree    <= w_tree_d;
            r_vld     <= {r_vld[LEVELS-1:0], in_valid};
            r_fst     <= {r_fst[LEVELS-1:0], in_first};
            out_valid <= r_vld[LEVELS];
            if (r_vld[LEVELS]) begin
                out_sum <= w_acc ? out_sum + w_root_ext : w_root_ext;
            end
        end
    end
endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb/tb_adder_tree_pipe.sv - directed self-checking bench for adder_tree_pipe
module tb_adder_tree_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Unsigned, 8 x 128, default ACC_WIDTH = 139
    logic [1023:0] a_data  = '0;
    logic          a_first = 1'b0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [138:0]  a_sum;
    logic          a_ovalid;
    logic          a_oready = 1'b1;

    // Signed, 8 x 8, default ACC_WIDTH = 19
    logic [63:0]   b_data  = '0;
    logic          b_first = 1'b0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [18:0]   b_sum;
    logic          b_ovalid;
    logic          b_oready = 1'b1;

    // Unsigned accumulate, 8 x 8, ACC_WIDTH = 11 (minimum)
    logic [63:0]   c_data  = '0;
    logic          c_first = 1'b0;
    logic          c_valid = 1'b0;
    logic          c_ready;
    logic [10:0]   c_sum;
    logic          c_ovalid;
    logic          c_oready = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    adder_tree_pipe #(.NUM_INPUTS(8), .IN_WIDTH(128), .SIGNED(0), .ACC_EN(0)) u_uns (
        .clk(clk), .rst(rst), .in_data(a_data), .in_first(a_first), .in_valid(a_valid),
        .in_ready(a_ready), .out_sum(a_sum), .out_valid(a_ovalid), .out_ready(a_oready));

    adder_tree_pipe #(.NUM_INPUTS(8), .IN_WIDTH(8), .SIGNED(1), .ACC_EN(0)) u_sgn (
        .clk(clk), .rst(rst), .in_data(b_data), .in_first(b_first), .in_valid(b_valid),
        .in_ready(b_ready), .out_sum(b_sum), .out_valid(b_ovalid), .out_ready(b_oready));

    adder_tree_pipe #(.NUM_INPUTS(8), .IN_WIDTH(8), .SIGNED(0), .ACC_EN(1), .ACC_WIDTH(11)) u_acc (
        .clk(clk), .rst(rst), .in_data(c_data), .in_first(c_first), .in_valid(c_valid),
        .in_ready(c_ready), .out_sum(c_sum), .out_valid(c_ovalid), .out_ready(c_oready));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_b(input logic [63:0] d);
        b_data  = d;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic wait_b(input string tag, input logic [18:0] exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (b_ovalid) begin
                seen = 1'b1;
                chk(tag, b_sum, exp);
            end
        end
        chk({tag, "_seen"}, seen, 1'b1);
    endtask

    task automatic acc_step(input string tag, input logic [63:0] d, input logic f, input logic [10:0] exp);
        bit seen;
        c_data  = d;
        c_first = f;
        c_valid = 1'b1;
        @(negedge clk);
        c_valid = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (c_ovalid) begin
                seen = 1'b1;
                chk(tag, c_sum, exp);
            end
        end
        chk({tag, "_seen"}, seen, 1'b1);
    endtask

    // 20 vectors, lane i = i + base + n; out_ready dropped for cycles stall_lo..stall_hi.
    task automatic run_stream(input string tag, input int base, input int stall_lo, input int stall_hi);
        int t_in;
        int k;
        bit stall;
        bit x_in;
        bit x_out;
        logic [138:0] prev;
        t_in = 0;
        k    = 0;
        prev = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            stall    = (c >= stall_lo) && (c <= stall_hi);
            a_oready = !stall;
            a_valid  = (t_in < 20);
            for (int i = 0; i < 8; i++) a_data[i*128 +: 128] = 128'(i + base + t_in);
            #1;
            chk({tag, "_in_ready"}, a_ready, !stall);
            if (stall && c > stall_lo) begin
                chk({tag, "_stall_sum"}, a_sum, prev);
                chk({tag, "_stall_valid"}, a_ovalid, 1'b1);
            end
            x_out = a_ovalid && a_oready;
            x_in  = a_valid && a_ready;
            if (x_out) chk({tag, "_sum"}, a_sum, 139'(28 + 8 * (base + k)));
            if (x_out) k++;
            if (x_in) t_in++;
            prev = a_sum;
        end
        a_valid  = 1'b0;
        a_oready = 1'b1;
        chk({tag, "_out_count"}, k, 20);
        chk({tag, "_in_count"}, t_in, 20);
    endtask

    initial begin
        logic [138:0] e_max;
        int seen_cnt;
        e_max = (139'(1) << 131) - 139'd8;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", a_ovalid, 1'b0);
        chk("rst_out_sum", a_sum, 139'd0);
        chk("rst_in_ready", a_ready, 1'b1);
        chk("rst_acc_sum", c_sum, 11'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_out_valid", a_ovalid, 1'b0);

        // Latency: accepted on edge e0, out_valid after edge e4
        a_data  = {1024{1'b1}};
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("lat_early", a_ovalid, 1'b0);
        @(negedge clk);
        chk("lat_valid", a_ovalid, 1'b1);
        chk("max_sum", a_sum, e_max);
        @(negedge clk);
        chk("max_drop", a_ovalid, 1'b0);
        chk("max_hold", a_sum, e_max);

        send_b({8{8'h80}});
        wait_b("sgn_min", 19'h7FC00);
        send_b({48'd0, 8'hFF, 8'h7F});
        wait_b("sgn_mix", 19'd126);

        acc_step("acc_first", {8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 1'b1, 11'd10);
        acc_step("acc_2", {8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 11'd20);
        acc_step("acc_3", {8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 11'd30);
        acc_step("acc_restart", {56'd0, 8'd5}, 1'b1, 11'd5);
        acc_step("acc_max", {8{8'hFF}}, 1'b1, 11'd2040);
        acc_step("acc_wrap", {8{8'hFF}}, 1'b0, 11'd2032);

        run_stream("stream", 0, -1, -1);
        run_stream("bp", 100, 8, 14);

        // Reset with vectors in flight
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) a_data[i*128 +: 128] = 128'(i);
            a_valid = 1'b1;
        end
        @(negedge clk);
        a_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", a_ovalid, 1'b0);
        chk("mid_rst_sum", a_sum, 139'd0);
        @(negedge clk);
        rst = 1'b0;
        a_data  = '0;
        for (int i = 0; i < 8; i++) a_data[i*128 +: 128] = 128'd1;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid  = 1'b0;
        seen_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_ovalid) begin
                seen_cnt++;
                chk("post_rst_sum", a_sum, 139'd8);
            end
        end
        chk("post_rst_count", seen_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
